cgra_cfg_loader: RTL and testbench

Configuration bitstream loader that sits directly upstream of the cgra2_2 fabric.
- A host writes the configuration image word-by-word into a local bit memory.
- On start, the block drives program_mode high and serialises the image, one bit per clock, onto the fabric's jtag_data_in.
- In verify mode it shifts the image twice and compares the bits returning on the fabric's jtag_data_out against the image, so the fabric is both loaded and checked.

---
 rtl/cgra_cfg_pkg.sv | 16 +
 rtl/cgra_cfg_bitmem.sv | 32 +++
 rtl/cgra_cfg_loader.sv | 109 ++++++++++
 tb/tb_cgra_cfg_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration loader: default sizes,
// loader state encoding and the mismatch counter width.
package cgra_cfg_pkg;

   localparam int CFG_BITS_DEF = 4096;
   localparam int WORD_W_DEF   = 32;
   localparam int ERR_W        = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT1 = 2'd1,
      SHIFT2 = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/cgra_cfg_bitmem.sv
// Configuration image store: one write port for the host, one synchronous
// word read for the serialiser. The image is never reset so it survives a
// reset of the loader.
module cgra_cfg_bitmem
   import cgra_cfg_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int DEPTH  = CFG_BITS_DEF / WORD_W_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Host word write.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read; a same-cycle write to the read address is forwarded.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
      else                               rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cgra_cfg_loader.sv
// Serialises the stored configuration image onto the fabric scan chain,
// optionally shifting it a second time and comparing the bits that return.
module cgra_cfg_loader
   import cgra_cfg_pkg::*;
#(
   parameter int CFG_BITS = CFG_BITS_DEF,
   parameter int WORD_W   = WORD_W_DEF,
   parameter int ADDR_W   = $clog2(CFG_BITS / WORD_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              start,
   input  logic              verify_en,
   output logic              program_mode,
   output logic              jtag_data_out,
   input  logic              jtag_data_in,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ERR_W-1:0]  err_count
);

   localparam int CNT_W = $clog2(CFG_BITS);
   localparam int WB    = $clog2(WORD_W);
   localparam int DEPTH = CFG_BITS / WORD_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_BITS - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_inc, cnt_nxt;
   logic              verify_q;
   logic              accept, wr_ok, shift_nxt, jtag_nxt, mismatch;
   logic [ADDR_W-1:0] rd_addr, cur_addr;
   logic [WORD_W-1:0] rd_data, cur_word;

   // cnt is the index of the next bit to drive, so it runs one ahead of the
   // wire and has already wrapped to 0 while the final bit of a pass is out.
   assign wr_ok    = wr_en && (state == IDLE);
   assign accept   = start && (state == IDLE);
   assign cnt_inc  = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
   assign rd_addr  = ADDR_W'(cnt_inc >> WB);
   assign cur_addr = ADDR_W'(cnt >> WB);
   assign cur_word = (wr_ok && (wr_addr == cur_addr)) ? wr_data : rd_data;

   assign program_mode = (state == SHIFT1) || (state == SHIFT2);
   assign busy         = program_mode;
   assign done         = (state == DONE);
   assign mismatch     = (state == SHIFT2) && (jtag_data_in != jtag_data_out);

   cgra_cfg_bitmem #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Next-state, next-bit and next-counter selection.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT1;
         SHIFT1:  if (cnt == '0) state_nxt = verify_q ? SHIFT2 : DONE;
         SHIFT2:  if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      shift_nxt = (state_nxt == SHIFT1) || (state_nxt == SHIFT2);
      jtag_nxt  = shift_nxt ? cur_word[cnt[WB-1:0]] : 1'b0;
      cnt_nxt   = shift_nxt ? cnt_inc : '0;
   end

   // State, bit counter, serial output and latched verify mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         jtag_data_out <= 1'b0;
         verify_q      <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         jtag_data_out <= jtag_nxt;
         if (accept) verify_q <= verify_en;
      end
   end

   // Sticky readback error flag and saturating mismatch count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         error     <= 1'b0;
         err_count <= '0;
      end else if (accept) begin
         error     <= 1'b0;
         err_count <= '0;
      end else if (mismatch) begin
         error <= 1'b1;
         if (err_count != '1) err_count <= err_count + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Bench for the configuration loader with a 64-bit scan chain fabric model.
module tb_cgra_cfg_loader;

   localparam int CFG_BITS = 64;
   localparam int WORD_W   = 32;
   localparam int ADDR_W   = 1;
   localparam logic [63:0] IMAGE = 64'h12345678DEADBEEF;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [WORD_W-1:0] wr_data = '0;
   logic              start = 1'b0;
   logic              verify_en = 1'b0;
   logic              program_mode, jtag_data_out, jtag_data_in;
   logic              busy, done, error;
   logic [15:0]       err_count;

   int assertions = 0;
   int failures   = 0;

   logic [CFG_BITS-1:0] img = '0;
   logic [CFG_BITS-1:0] fab = '0;
   int                  fab_cnt = 0;
   logic                force_en = 1'b0;
   logic [CFG_BITS-1:0] force_mask = '0;

   logic exp_q[$];
   logic obs_q[$];
   int   pm_cycles, done_cnt, done_at;
   logic first_err;
   logic [15:0] first_cnt;
   logic rst_pm, rst_busy, rst_done, rst_out;

   always #5 clk = ~clk;

   cgra_cfg_loader #(
      .CFG_BITS (CFG_BITS),
      .WORD_W   (WORD_W),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .start         (start),
      .verify_en     (verify_en),
      .program_mode  (program_mode),
      .jtag_data_out (jtag_data_out),
      .jtag_data_in  (jtag_data_in),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .err_count     (err_count)
   );

   // Fabric scan chain: shifts toward bit 0 while program_mode is high.
   always @(posedge clk) begin
      if (program_mode) begin
         fab     <= {jtag_data_out, fab[CFG_BITS-1:1]};
         fab_cnt <= fab_cnt + 1;
      end else begin
         fab_cnt <= 0;
      end
   end

   // Chain output, optionally forced high at chosen second-pass positions.
   always_comb begin
      jtag_data_in = fab[0];
      if (force_en && fab_cnt >= CFG_BITS && fab_cnt < 2 * CFG_BITS)
         if (force_mask[fab_cnt - CFG_BITS]) jtag_data_in = 1'b1;
   end

   task automatic write_word(input int addr, input logic [WORD_W-1:0] data);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(addr);
      wr_data = data;
      img[addr*WORD_W +: WORD_W] = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Starts a load, queues the expected stream and records what the DUT does.
   task automatic run_load(input bit v, input int lock_at, input int rst_at, input int budget);
      int cyc;
      bit stop;
      exp_q.delete();
      obs_q.delete();
      pm_cycles = 0;
      done_cnt  = 0;
      done_at   = -1;
      @(negedge clk);
      start     = 1'b1;
      verify_en = v;
      for (int p = 0; p < (v ? 2 : 1); p++)
         for (int i = 0; i < CFG_BITS; i++) exp_q.push_back(img[i]);
      @(negedge clk);
      start     = 1'b0;
      verify_en = 1'b0;
      cyc  = 1;
      stop = 1'b0;
      while (!stop && cyc <= budget) begin
         if (cyc == 1) begin
            first_err = error;
            first_cnt = err_count;
         end
         if (program_mode === 1'b1) begin
            pm_cycles++;
            obs_q.push_back(jtag_data_out);
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
         end
         if (cyc == lock_at) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = '0;
         end else begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         if (cyc == rst_at) begin
            rst = 1'b0;
            #1;
            rst_pm   = program_mode;
            rst_busy = busy;
            rst_done = done;
            rst_out  = jtag_data_out;
            stop     = 1'b1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic test_reset;
      bit seen;
      rst   = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      assertions += 6;
      if (program_mode !== 1'b0) begin failures++; $display("[TB] FAIL reset program_mode: got %b expected 0", program_mode); end
      if (jtag_data_out !== 1'b0) begin failures++; $display("[TB] FAIL reset jtag_data_out: got %b expected 0", jtag_data_out); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset done: got %b expected 0", done); end
      if (error !== 1'b0) begin failures++; $display("[TB] FAIL reset error: got %b expected 0", error); end
      if (err_count !== 16'h0) begin failures++; $display("[TB] FAIL reset err_count: got %0h expected 0", err_count); end
      rst   = 1'b1;
      start = 1'b0;
      seen  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (program_mode !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      assertions++;
      if (seen !== 1'b0) begin failures++; $display("[TB] FAIL idle after reset: got active %b expected 0", seen); end
   endtask

   task automatic test_plain_load;
      int idx;
      logic e, o;
      write_word(0, 32'hDEADBEEF);
      write_word(1, 32'h12345678);
      run_load(1'b0, -1, -1, 140);
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz;
         assertions++;
         if (o !== e) begin failures++; $display("[TB] FAIL plain stream bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      assertions += 4;
      if (pm_cycles != 64) begin failures++; $display("[TB] FAIL plain program_mode cycles: got %0d expected 64", pm_cycles); end
      if (done_cnt != 1) begin failures++; $display("[TB] FAIL plain done pulses: got %0d expected 1", done_cnt); end
      if (done_at != 65) begin failures++; $display("[TB] FAIL plain done cycle: got %0d expected 65", done_at); end
      if (fab !== IMAGE) begin failures++; $display("[TB] FAIL plain fabric image: got %h expected %h", fab, IMAGE); end
   endtask

   task automatic test_verify_pass;
      int idx;
      logic e, o;
      force_en = 1'b0;
      run_load(1'b1, -1, -1, 200);
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz;
         assertions++;
         if (o !== e) begin failures++; $display("[TB] FAIL verify stream bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      assertions += 6;
      if (pm_cycles != 128) begin failures++; $display("[TB] FAIL verify program_mode cycles: got %0d expected 128", pm_cycles); end
      if (done_cnt != 1) begin failures++; $display("[TB] FAIL verify done pulses: got %0d expected 1", done_cnt); end
      if (done_at != 129) begin failures++; $display("[TB] FAIL verify done cycle: got %0d expected 129", done_at); end
      if (error !== 1'b0) begin failures++; $display("[TB] FAIL verify error: got %b expected 0", error); end
      if (err_count !== 16'd0) begin failures++; $display("[TB] FAIL verify err_count: got %0d expected 0", err_count); end
      if (fab !== IMAGE) begin failures++; $display("[TB] FAIL verify fabric image: got %h expected %h", fab, IMAGE); end
   endtask

   task automatic test_verify_fail;
      // Bits 4, 8 and 14 of the image are zero; force them to return as one.
      force_mask = '0;
      force_mask[4]  = 1'b1;
      force_mask[8]  = 1'b1;
      force_mask[14] = 1'b1;
      force_en = 1'b1;
      run_load(1'b1, -1, -1, 200);
      force_en = 1'b0;
      assertions += 3;
      if (error !== 1'b1) begin failures++; $display("[TB] FAIL verify-fail error: got %b expected 1", error); end
      if (err_count !== 16'd3) begin failures++; $display("[TB] FAIL verify-fail err_count: got %0d expected 3", err_count); end
      if (done_cnt != 1) begin failures++; $display("[TB] FAIL verify-fail done pulses: got %0d expected 1", done_cnt); end
      run_load(1'b0, -1, -1, 140);
      assertions += 3;
      if (first_err !== 1'b0) begin failures++; $display("[TB] FAIL restart clears error: got %b expected 0", first_err); end
      if (first_cnt !== 16'd0) begin failures++; $display("[TB] FAIL restart clears err_count: got %0d expected 0", first_cnt); end
      if (error !== 1'b0) begin failures++; $display("[TB] FAIL plain after fail error: got %b expected 0", error); end
   endtask

   task automatic test_busy_lockout;
      int idx;
      logic e, o;
      run_load(1'b0, 10, -1, 140);
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz;
         assertions++;
         if (o !== e) begin failures++; $display("[TB] FAIL lockout stream bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      assertions += 2;
      if (pm_cycles != 64) begin failures++; $display("[TB] FAIL lockout program_mode cycles: got %0d expected 64", pm_cycles); end
      if (done_cnt != 1) begin failures++; $display("[TB] FAIL lockout done pulses: got %0d expected 1", done_cnt); end
      run_load(1'b0, -1, -1, 140);
      assertions++;
      if (fab !== IMAGE) begin failures++; $display("[TB] FAIL lockout memory kept: got %h expected %h", fab, IMAGE); end
   endtask

   task automatic test_reset_midload;
      int idx;
      logic e, o;
      run_load(1'b0, -1, 21, 140);
      idx = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         assertions++;
         if (o !== e) begin failures++; $display("[TB] FAIL pre-reset stream bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      assertions += 5;
      if (idx != 21) begin failures++; $display("[TB] FAIL pre-reset bits: got %0d expected 21", idx); end
      if (rst_pm !== 1'b0) begin failures++; $display("[TB] FAIL reset mid-load program_mode: got %b expected 0", rst_pm); end
      if (rst_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset mid-load busy: got %b expected 0", rst_busy); end
      if (rst_done !== 1'b0) begin failures++; $display("[TB] FAIL reset mid-load done: got %b expected 0", rst_done); end
      if (rst_out !== 1'b0) begin failures++; $display("[TB] FAIL reset mid-load jtag_data_out: got %b expected 0", rst_out); end
      @(negedge clk);
      rst = 1'b1;
      fab = '0;
      run_load(1'b0, -1, -1, 140);
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz;
         assertions++;
         if (o !== e) begin failures++; $display("[TB] FAIL reload stream bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      assertions += 2;
      if (pm_cycles != 64) begin failures++; $display("[TB] FAIL reload program_mode cycles: got %0d expected 64", pm_cycles); end
      if (fab !== IMAGE) begin failures++; $display("[TB] FAIL reload fabric image: got %h expected %h", fab, IMAGE); end
   endtask

   initial begin
      test_reset();
      test_plain_load();
      test_verify_pass();
      test_verify_fail();
      test_busy_lockout();
      test_reset_midload();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
